// File: rtl/ucode_exec.sv
// Microcode execution unit: decodes a registered microinstruction into a bus mux, load strobes,
// RAM control and the PC/AR/MDR/IR/LED register file.
// Latency: one cycle from ucode to strobes and bus; register loads land at the end of that cycle.
// Backpressure: none; a new microinstruction is accepted every cycle.
//
// Ports:
//   clk, rst_n             single clock, synchronous active-low reset
//   ucode[UW-1:0]          {S[25:22], M[21], WE[20], A[19:16], B[15:12], C[11:8], UA[7:0]}
//   r0_q..ram_q, *_flag    bus source data and flag sources
//   bus                    internal data bus, selected by B
//   ld_*                   one-hot load strobes decoded from A
//   alu_s, alu_m           S and M fields passed straight to the ALU
//   ram_addr/wdata/we/re   RAM port (address is the AR register)
//   pc, ir, led            register contents
// Optional: define UCODE_TRACE_EN to add trace_cnt / trace_last (count and copy of executed
// non-no-op microinstructions).

module ucode_exec #(
    parameter int UW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [UW-1:0] ucode,
    input  logic [7:0]    r0_q,
    input  logic [7:0]    r1_q,
    input  logic [7:0]    r2_q,
    input  logic [7:0]    alu_q,
    input  logic [7:0]    sheft_q,
    input  logic [7:0]    sw_in,
    input  logic [7:0]    ram_q,
    input  logic          alu_flag,
    input  logic          sheft_flag,
    input  logic          flag_q,
    output logic [7:0]    bus,
    output logic          ld_r0,
    output logic          ld_r1,
    output logic          ld_r2,
    output logic          ld_dr1,
    output logic          ld_dr2,
    output logic          ld_alucn,
    output logic          ld_sheft,
    output logic          ld_flag,
    output logic [3:0]    alu_s,
    output logic          alu_m,
    output logic [7:0]    ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [7:0]    pc,
    output logic [7:0]    ir,
    output logic [7:0]    led
`ifdef UCODE_TRACE_EN
    ,
    output logic [15:0]   trace_cnt,
    output logic [UW-1:0] trace_last
`endif
);

    // A-field destination codes
    localparam logic [3:0] A_NOP    = 4'h0;
    localparam logic [3:0] A_R0     = 4'h1;
    localparam logic [3:0] A_R1     = 4'h2;
    localparam logic [3:0] A_R2     = 4'h3;
    localparam logic [3:0] A_DR1    = 4'h4;
    localparam logic [3:0] A_DR2    = 4'h5;
    localparam logic [3:0] A_ALUCN  = 4'h6;
    localparam logic [3:0] A_SHEFT  = 4'h7;
    localparam logic [3:0] A_FLAG   = 4'h8;
    localparam logic [3:0] A_LDRAM  = 4'h9;
    localparam logic [3:0] A_LDRAMD = 4'hA;
    localparam logic [3:0] A_LDPC   = 4'hB;
    localparam logic [3:0] A_INCPC  = 4'hC;
    localparam logic [3:0] A_LDLED  = 4'hD;
    localparam logic [3:0] A_LDIR   = 4'hE;
    localparam logic [3:0] A_NOP2   = 4'hF;

    logic [UW-1:0] uir;
    logic [3:0]    f_s;
    logic          f_m;
    logic          f_we;
    logic [3:0]    f_a;
    logic [3:0]    f_b;
    logic [7:0]    ar;
    logic [7:0]    mdr;

    // Microinstruction register: every decode below comes from here, never from ucode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uir <= '0;
        end else begin
            uir <= ucode;
        end
    end

    assign f_s  = uir[25:22];
    assign f_m  = uir[21];
    assign f_we = uir[20];
    assign f_a  = uir[19:16];
    assign f_b  = uir[15:12];

`ifndef UCODE_TRACE_EN
    // C and UA belong to the sequencer; nothing here consumes them without tracing.
    logic unused_fields;
    assign unused_fields = ^uir[11:0];
`endif

    // Bus source select
    always_comb begin
        bus = 8'h00;
        case (f_b)
            4'h0:    bus = 8'h00;
            4'h1:    bus = sw_in;
            4'h2:    bus = r0_q;
            4'h3:    bus = r1_q;
            4'h4:    bus = r2_q;
            4'h5:    bus = alu_q;
            4'h6:    bus = {7'b0, alu_flag};
            4'h7:    bus = sheft_q;
            4'h8:    bus = {7'b0, sheft_flag};
            4'h9:    bus = {7'b0, flag_q};
            4'hA:    bus = mdr;
            4'hB:    bus = pc;
            default: bus = 8'h00;
        endcase
    end

    // External load strobes: a single A field guarantees at most one is high.
    always_comb begin
        ld_r0    = 1'b0;
        ld_r1    = 1'b0;
        ld_r2    = 1'b0;
        ld_dr1   = 1'b0;
        ld_dr2   = 1'b0;
        ld_alucn = 1'b0;
        ld_sheft = 1'b0;
        ld_flag  = 1'b0;
        case (f_a)
            A_R0:    ld_r0    = 1'b1;
            A_R1:    ld_r1    = 1'b1;
            A_R2:    ld_r2    = 1'b1;
            A_DR1:   ld_dr1   = 1'b1;
            A_DR2:   ld_dr2   = 1'b1;
            A_ALUCN: ld_alucn = 1'b1;
            A_SHEFT: ld_sheft = 1'b1;
            A_FLAG:  ld_flag  = 1'b1;
            default: ;
        endcase
    end

    // WE only means something alongside LDRAM; it selects write versus read.
    assign ram_we    = (f_a == A_LDRAM) &&  f_we;
    assign ram_re    = (f_a == A_LDRAM) && !f_we;
    assign ram_wdata = bus;
    assign ram_addr  = ar;

    assign alu_s = f_s;
    assign alu_m = f_m;

    // Internal register file. INCPC reads the old pc, so B=pc alongside INCPC
    // puts the pre-increment value on the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc  <= 8'h00;
            ar  <= 8'h00;
            mdr <= 8'h00;
            ir  <= 8'h00;
            led <= 8'h00;
        end else begin
            case (f_a)
                A_LDRAMD: ar  <= bus;
                A_LDRAM:  if (!f_we) mdr <= ram_q;
                A_LDPC:   pc  <= bus;
                A_INCPC:  pc  <= pc + 8'd1;
                A_LDLED:  led <= bus;
                A_LDIR:   ir  <= bus;
                default:  ;
            endcase
        end
    end

`ifdef UCODE_TRACE_EN
    logic active;
    assign active = (f_a != A_NOP) && (f_a != A_NOP2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_cnt  <= 16'h0000;
            trace_last <= '0;
        end else if (active) begin
            trace_cnt  <= trace_cnt + 16'd1;
            trace_last <= uir;
        end
    end
`endif

endmodule

// File: tb/tb_ucode_exec.sv
// Directed bench for ucode_exec with a reference model feeding an expectation queue.
// Latency: expectations are compared one cycle after the matching ucode is driven.
// Backpressure: not applicable.

module tb_ucode_exec;

    localparam int UW = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [UW-1:0] ucode;
    logic [7:0]    r0_q, r1_q, r2_q, alu_q, sheft_q, sw_in, ram_q;
    logic          alu_flag, sheft_flag, flag_q;
    logic [7:0]    bus;
    logic          ld_r0, ld_r1, ld_r2, ld_dr1, ld_dr2, ld_alucn, ld_sheft, ld_flag;
    logic [3:0]    alu_s;
    logic          alu_m;
    logic [7:0]    ram_addr, ram_wdata;
    logic          ram_we, ram_re;
    logic [7:0]    pc, ir, led;
`ifdef UCODE_TRACE_EN
    logic [15:0]   trace_cnt;
    logic [UW-1:0] trace_last;
`endif

    always #5 clk = ~clk;

    ucode_exec #(.UW(UW)) dut (
        .clk(clk), .rst_n(rst_n), .ucode(ucode),
        .r0_q(r0_q), .r1_q(r1_q), .r2_q(r2_q), .alu_q(alu_q), .sheft_q(sheft_q),
        .sw_in(sw_in), .ram_q(ram_q),
        .alu_flag(alu_flag), .sheft_flag(sheft_flag), .flag_q(flag_q),
        .bus(bus),
        .ld_r0(ld_r0), .ld_r1(ld_r1), .ld_r2(ld_r2), .ld_dr1(ld_dr1), .ld_dr2(ld_dr2),
        .ld_alucn(ld_alucn), .ld_sheft(ld_sheft), .ld_flag(ld_flag),
        .alu_s(alu_s), .alu_m(alu_m),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .pc(pc), .ir(ir), .led(led)
`ifdef UCODE_TRACE_EN
        , .trace_cnt(trace_cnt), .trace_last(trace_last)
`endif
    );

    typedef struct {
        logic [7:0] bus;
        logic [7:0] stb;
        logic       we;
        logic       re;
        logic [7:0] wdata;
        logic [3:0] s;
        logic       m;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [7:0] led;
        logic [7:0] addr;
    } exp_t;

    exp_t q[$];

    // Reference model state (what the DUT registers should hold)
    logic [7:0] m_pc, m_ar, m_mdr, m_ir, m_led;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mbus(input logic [3:0] b);
        case (b)
            4'h1:    return sw_in;
            4'h2:    return r0_q;
            4'h3:    return r1_q;
            4'h4:    return r2_q;
            4'h5:    return alu_q;
            4'h6:    return {7'b0, alu_flag};
            4'h7:    return sheft_q;
            4'h8:    return {7'b0, sheft_flag};
            4'h9:    return {7'b0, flag_q};
            4'hA:    return m_mdr;
            4'hB:    return m_pc;
            default: return 8'h00;
        endcase
    endfunction

    task automatic compare_pending();
        exp_t e;
        logic [7:0] stb;
        if (q.size() != 0) begin
            e   = q.pop_front();
            stb = {ld_flag, ld_sheft, ld_alucn, ld_dr2, ld_dr1, ld_r2, ld_r1, ld_r0};
            chk("bus", bus, e.bus);
            chk("strobes", stb, e.stb);
            chk("onehot", ($countones(stb) <= 1), 1);
            chk("ram_we", ram_we, e.we);
            chk("ram_re", ram_re, e.re);
            if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
            chk("alu_s", alu_s, e.s);
            chk("alu_m", alu_m, e.m);
            chk("pc", pc, e.pc);
            chk("ir", ir, e.ir);
            chk("led", led, e.led);
            chk("ram_addr", ram_addr, e.addr);
        end
    endtask

    // Compare the instruction currently in uir, then present the next one and
    // queue what the DUT should show while it sits in uir.
    task automatic step(input logic [3:0] s, input logic m, input logic we,
                        input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [11:0] junk;
        @(negedge clk);
        compare_pending();
        junk  = 12'($urandom);
        ucode = {s, m, we, a, b, junk};
        e.bus   = mbus(b);
        e.stb   = (a >= 4'h1 && a <= 4'h8) ? (8'h01 << (a - 4'h1)) : 8'h00;
        e.we    = (a == 4'h9) && we;
        e.re    = (a == 4'h9) && !we;
        e.wdata = e.bus;
        e.s     = s;
        e.m     = m;
        e.pc    = m_pc;
        e.ir    = m_ir;
        e.led   = m_led;
        e.addr  = m_ar;
        q.push_back(e);
        case (a)
            4'h9: if (!we) m_mdr = ram_q;
            4'hA: m_ar  = e.bus;
            4'hB: m_pc  = e.bus;
            4'hC: m_pc  = m_pc + 8'd1;
            4'hD: m_led = e.bus;
            4'hE: m_ir  = e.bus;
            default: ;
        endcase
    endtask

    // Leaves the DUT with a no-op in uir so data inputs can change safely.
    task automatic nop_settle();
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
    endtask

    // Reset while an LDPC is pending: the pending load must be suppressed.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        compare_pending();
        rst_n = 1'b0;
        ucode = {4'hF, 1'b1, 1'b1, 4'hB, 4'h1, 12'hABC};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ucode = '0;
        m_pc = 8'h00; m_ar = 8'h00; m_mdr = 8'h00; m_ir = 8'h00; m_led = 8'h00;
        e.bus = 8'h00; e.stb = 8'h00; e.we = 1'b0; e.re = 1'b0; e.wdata = 8'h00;
        e.s = 4'h0; e.m = 1'b0; e.pc = 8'h00; e.ir = 8'h00; e.led = 8'h00; e.addr = 8'h00;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ucode = '0;
        r0_q = 8'h5A; r1_q = 8'h11; r2_q = 8'h22; alu_q = 8'h33; sheft_q = 8'h44;
        sw_in = 8'h3C; ram_q = 8'h77;
        alu_flag = 1'b1; sheft_flag = 1'b0; flag_q = 1'b1;
        m_pc = 8'h00; m_ar = 8'h00; m_mdr = 8'h00; m_ir = 8'h00; m_led = 8'h00;
        repeat (2) @(posedge clk);

        do_reset();

        // pc <= sw_in, then AR <= pc
        step(4'h0, 1'b0, 1'b0, 4'hB, 4'h1);
        step(4'h0, 1'b0, 1'b0, 4'hA, 4'hB);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("pc_3c", pc, 8'h3C);
        chk("ram_addr_3c", ram_addr, 8'h3C);

        // RAM read into mdr, mdr to ir, RAM write must leave mdr alone
        step(4'h0, 1'b0, 1'b0, 4'h9, 4'h0);
        step(4'h0, 1'b0, 1'b0, 4'hE, 4'hA);
        step(4'h5, 1'b1, 1'b1, 4'h9, 4'h2);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'hA);
        // LED load with WE set: ram_we must stay low
        step(4'hA, 1'b0, 1'b1, 4'hD, 4'h3);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("ir_77", ir, 8'h77);
        chk("led_11", led, 8'h11);

        // Strobe decode, plus A=F with WE set as a no-op
        for (int a = 1; a <= 8; a++) step(4'(a), 1'(a), 1'b1, 4'(a), 4'h5);
        step(4'h3, 1'b1, 1'b1, 4'hF, 4'h7);

        // Bus source sweep
        for (int b = 0; b < 16; b++) step(4'(15 - b), 1'b0, 1'b0, 4'h0, 4'(b));

        // pc wrap: pc <= FF, then INCPC with the pre-increment pc on the bus
        nop_settle();
        sw_in = 8'hFF;
        step(4'h0, 1'b0, 1'b0, 4'hB, 4'h1);
        step(4'h0, 1'b0, 1'b0, 4'hC, 4'hB);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("pc_wrap", pc, 8'h00);

        // Reset in the middle of a sequence
        step(4'h0, 1'b0, 1'b0, 4'hB, 4'h2);
        do_reset();
        step(4'h0, 1'b0, 1'b0, 4'hB, 4'h1);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'hB);

        // Drain
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        compare_pending();
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
